// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// MUL is shift-add and DIV is restoring division, one bit per cycle over
// magnitudes; the sign is restored in a final FIX cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         request; op 00=MUL 01=DIV 10=MTHI 11=MTLO
//   ifunsigned        1 = unsigned operands, 0 = two's complement
//   A, B              operands (A is also the MTHI/MTLO data)
//   busy, done, dbz   in flight / one-cycle result pulse / divide by zero
//   hi, lo            HI (product upper / remainder), LO (product lower / quotient)
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO complete here
// RUN   | one multiplier or quotient bit per cycle, counter counts down
// FIX   | sign correction and HI/LO write, done raised next cycle
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             ifunsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               is_div, div_zero, neg_res, neg_rem;
    logic [WIDTH-1:0]   opa, opb;
    logic [2*WIDTH-1:0] acc;

    logic               accept, md_req, b_zero;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   quo, rem;

    assign accept = start && (state == IDLE);
    assign md_req = accept && !op[1];
    assign b_zero = (B == '0);
    assign a_neg  = !ifunsigned && A[WIDTH-1];
    assign b_neg  = !ifunsigned && B[WIDTH-1];
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;

    // MUL: acc = {partial product, remaining multiplier bits}, shifted right.
    // DIV: acc = {partial remainder, dividend/quotient bits}, shifted left;
    // div_shift carries the guard bit of the shifted-in remainder.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opb});
    assign div_rem   = div_ok ? WIDTH'(div_shift - {1'b0, opb}) : div_shift[WIDTH-1:0];
    assign acc_step  = is_div ? {div_rem, acc[WIDTH-2:0], div_ok}
                              : {mul_sum, acc[WIDTH-1:1]};

    assign prod = neg_res ? -acc : acc;
    assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (md_req) state_nx = (op[0] && b_zero) ? FIX : RUN;
            RUN:     if (cnt == CW'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            2'b10: hi <= A;
                            2'b11: lo <= A;
                            default: begin
                                // divide by zero keeps raw A in opa for hi
                                opa      <= (op[0] && b_zero) ? A : a_mag;
                                opb      <= b_mag;
                                is_div   <= op[0];
                                div_zero <= op[0] && b_zero;
                                neg_res  <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                                dbz      <= 1'b0;
                                cnt      <= CW'(WIDTH);
                                acc      <= {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
                            end
                        endcase
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    if (div_zero) begin
                        hi  <= opa;
                        lo  <= '1;
                        dbz <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        {hi, lo} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: WIDTH=32 instance, index 1: WIDTH=8 instance
    logic        rst_s   [2];
    logic        start_s [2];
    logic [1:0]  op_s    [2];
    logic        uns_s   [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];

    logic        busy0, done0, dbz0, busy1, done1, dbz1;
    logic [31:0] hi0, lo0;
    logic [7:0]  hi1, lo1;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .op(op_s[0]),
        .ifunsigned(uns_s[0]), .A(a_s[0]), .B(b_s[0]),
        .busy(busy0), .done(done0), .dbz(dbz0), .hi(hi0), .lo(lo0)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .op(op_s[1]),
        .ifunsigned(uns_s[1]), .A(a_s[1][7:0]), .B(b_s[1][7:0]),
        .busy(busy1), .done(done1), .dbz(dbz1), .hi(hi1), .lo(lo1)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    function automatic int wid(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Architectural result from plain integer arithmetic.
    function automatic void ref_calc(input int w, input logic [1:0] o, input logic u,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l,
                                     output logic z);
        logic [63:0] m, ua, ub, p;
        longint sa, sb, sq, sr;
        m  = wmask(w);
        ua = {32'h0, a} & m;
        ub = {32'h0, b} & m;
        sa = (!u && ua[w-1]) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = (!u && ub[w-1]) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        z  = 1'b0;
        if (o == 2'b00) begin
            p = u ? ua * ub : 64'(sa * sb);
            h = 32'((p >> w) & m);
            l = 32'(p & m);
        end else if (ub == 64'd0) begin
            h = 32'(ua);
            l = 32'(m);
            z = 1'b1;
        end else if (u) begin
            h = 32'((ua % ub) & m);
            l = 32'((ua / ub) & m);
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            h = 32'(64'(sr) & m);
            l = 32'(64'(sq) & m);
        end
    endfunction

    // Cycle-level model: cycles left until done, pending result.
    logic        m_busy [2], m_done [2], m_dbz [2];
    logic [31:0] m_hi [2], m_lo [2];
    logic [31:0] p_hi [2], p_lo [2];
    logic        p_dbz [2];
    int          m_left [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_s[k]) begin
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_dbz[k] = 1'b0;
                m_hi[k] = '0; m_lo[k] = '0; m_left[k] = 0;
            end else begin
                m_done[k] = 1'b0;
                if (m_busy[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                        m_hi[k] = p_hi[k];
                        m_lo[k] = p_lo[k];
                        m_dbz[k] = p_dbz[k];
                    end
                end else if (start_s[k]) begin
                    if (op_s[k] == 2'b10) m_hi[k] = 32'({32'h0, a_s[k]} & wmask(wid(k)));
                    else if (op_s[k] == 2'b11) m_lo[k] = 32'({32'h0, a_s[k]} & wmask(wid(k)));
                    else begin
                        logic [31:0] th, tl;
                        logic tz;
                        ref_calc(wid(k), op_s[k], uns_s[k], a_s[k], b_s[k], th, tl, tz);
                        p_hi[k] = th; p_lo[k] = tl; p_dbz[k] = tz;
                        m_busy[k] = 1'b1;
                        m_dbz[k] = 1'b0;
                        m_left[k] = tz ? 1 : wid(k) + 1;
                    end
                end
            end
        end
    end

    task automatic cmp_one(input int k, input logic bz, input logic dn, input logic dz,
                           input logic [31:0] h, input logic [31:0] l);
        vectors++;
        if ({bz, dn, dz, h, l} !== {m_busy[k], m_done[k], m_dbz[k], m_hi[k], m_lo[k]}) begin
            miscompares++;
            $display("FAIL cycle_cmp w%0d t=%0t: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected busy=%b done=%b dbz=%b hi=%h lo=%h",
                     wid(k), $time, bz, dn, dz, h, l,
                     m_busy[k], m_done[k], m_dbz[k], m_hi[k], m_lo[k]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_one(0, busy0, done0, dbz0, hi0, lo0);
            cmp_one(1, busy1, done1, dbz1, {24'h0, hi1}, {24'h0, lo1});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one request on instance k across one edge; returns in cycle 1.
    task automatic issue(input int k, input logic [1:0] o, input logic u,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_s[k] = 1'b1; op_s[k] = o; uns_s[k] = u; a_s[k] = a; b_s[k] = b;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    // Wait (bounded) for done on instance 0; cyc is the current cycle number.
    task automatic wait_done(inout int cyc);
        while (!done0 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [31:0] rnd_opnd(input int w);
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'(wmask(w));
            3: return 32'(64'd1 << (w - 1));
            default: return 32'($urandom() & 32'(wmask(w)));
        endcase
    endfunction

    initial begin
        int cyc;
        logic [31:0] th, tl;
        logic tz;

        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1; start_s[k] = 1'b0; op_s[k] = 2'b00;
            uns_s[k] = 1'b1; a_s[k] = '0; b_s[k] = '0;
        end
        @(posedge clk);
        chk_en = 1'b1;

        ref_calc(32, 2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, th, tl, tz);
        chk("model_umul_hi", th, 32'hFFFFFFFE);
        chk("model_umul_lo", tl, 32'h00000001);
        ref_calc(32, 2'b01, 1'b0, 32'hFFFFFFF9, 32'd2, th, tl, tz);
        chk("model_sdiv_hi", th, 32'hFFFFFFFF);
        chk("model_sdiv_lo", tl, 32'hFFFFFFFD);
        ref_calc(8, 2'b00, 1'b0, 32'h80, 32'h80, th, tl, tz);
        chk("model_smul8", {th[15:0], tl[15:0]}, {16'h40, 16'h00});
        ref_calc(8, 2'b01, 1'b0, 32'h80, 32'hFF, th, tl, tz);
        chk("model_minneg1_8", {th[15:0], tl[15:0]}, {16'h00, 16'h80});
        ref_calc(8, 2'b01, 1'b1, 32'h80, 32'h00, th, tl, tz);
        chk("model_dbz8", {15'h0, tz, th[7:0], tl[7:0]}, {16'h1, 8'h80, 8'hFF});

        @(negedge clk);
        chk("reset_state", {29'h0, busy0, done0, dbz0}, 32'h0);
        chk("reset_hi_lo", hi0 | lo0, 32'h0);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;

        issue(0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cyc = 1;
        chk("umul_busy_c1", {31'h0, busy0}, 32'h1);
        wait_done(cyc);
        chk("umul_done_cycle", cyc, 34);
        chk("umul_hi", hi0, 32'hFFFFFFFE);
        chk("umul_lo", lo0, 32'h00000001);

        issue(0, 2'b00, 1'b0, 32'hFFFFFFFD, 32'd7);
        cyc = 1; wait_done(cyc);
        chk("smul_hi", hi0, 32'hFFFFFFFF);
        chk("smul_lo", lo0, 32'hFFFFFFEB);

        issue(0, 2'b01, 1'b0, 32'hFFFFFFF9, 32'd2);
        cyc = 1; wait_done(cyc);
        chk("sdiv_lo", lo0, 32'hFFFFFFFD);
        chk("sdiv_hi", hi0, 32'hFFFFFFFF);

        issue(0, 2'b01, 1'b1, 32'hFFFFFFF9, 32'd2);
        cyc = 1; wait_done(cyc);
        chk("udiv_lo", lo0, 32'h7FFFFFFC);
        chk("udiv_hi", hi0, 32'h00000001);

        issue(0, 2'b01, 1'b1, 32'h1234, 32'h0);
        cyc = 1; wait_done(cyc);
        chk("dbz_done_cycle", cyc, 2);
        chk("dbz_flag", {31'h0, dbz0}, 32'h1);
        chk("dbz_hi", hi0, 32'h1234);
        chk("dbz_lo", lo0, 32'hFFFFFFFF);

        issue(0, 2'b00, 1'b1, 32'd2, 32'd3);
        chk("dbz_cleared_at_accept", {31'h0, dbz0}, 32'h0);
        cyc = 1; wait_done(cyc);
        chk("mul23_lo", lo0, 32'd6);
        chk("mul23_hi", hi0, 32'd0);

        issue(0, 2'b01, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        cyc = 1; wait_done(cyc);
        chk("minneg1_lo", lo0, 32'h80000000);
        chk("minneg1_hi_dbz", hi0 | {31'h0, dbz0}, 32'h0);

        @(negedge clk);
        start_s[0] = 1'b1; op_s[0] = 2'b10; a_s[0] = 32'hAAAA0000;
        @(negedge clk);
        chk("mthi_c1", hi0, 32'hAAAA0000);
        chk("mthi_no_done", {31'h0, done0 | busy0}, 32'h0);
        op_s[0] = 2'b11; a_s[0] = 32'h5555;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("mtlo_c2", lo0, 32'h5555);
        chk("mtlo_no_done", {31'h0, done0 | busy0}, 32'h0);

        issue(0, 2'b00, 1'b1, 32'd5, 32'd6);
        cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        start_s[0] = 1'b1; op_s[0] = 2'b01; a_s[0] = 32'd100; b_s[0] = 32'd0;
        @(negedge clk); cyc++;
        start_s[0] = 1'b0;
        wait_done(cyc);
        chk("ignored_start_cycle", cyc, 34);
        chk("ignored_start_lo", lo0, 32'd30);
        chk("ignored_start_dbz", {31'h0, dbz0}, 32'h0);
        @(negedge clk);
        chk("ignored_start_idle", {31'h0, busy0}, 32'h0);

        issue(0, 2'b01, 1'b0, 32'd100, 32'd7);
        cyc = 1;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        chk("rst_abort_flags", {29'h0, busy0, done0, dbz0}, 32'h0);
        chk("rst_abort_hilo", hi0 | lo0, 32'h0);
        repeat (40) begin
            @(negedge clk);
            if (done0) chk("rst_no_done", {31'h0, done0}, 32'h0);
        end

        // Randomized traffic on both widths, checked every cycle by the model.
        for (int n = 0; n < 30000; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int sel;
                rst_s[k]   = ($urandom_range(0, 599) == 0);
                start_s[k] = ($urandom_range(0, 2) != 0);
                sel        = $urandom_range(0, 9);
                op_s[k]    = (sel < 4) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
                uns_s[k]   = $urandom_range(0, 1) == 1;
                a_s[k]     = rnd_opnd(wid(k));
                b_s[k]     = rnd_opnd(wid(k));
            end
        end
        @(negedge clk);
        start_s[0] = 1'b0; start_s[1] = 1'b0; rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
